// File: rtl/ln_mean_acc_ctrl.sv
// LayerNorm stage-1 accumulator sequencer: job config, beat gating, loop flags and reciprocal operand.
// Latency: 1 cycle from an accepted beat to acc_vld/acc_dat/flags; done DRAIN_CYC cycles after the last beat.
// Backpressure: in_rdy is high only in RUN; the source holds its data while in_rdy is low.
module ln_mean_acc_ctrl #(
    parameter int DW        = 16,
    parameter int TOUT      = 32,
    parameter int LOG2_TOUT = 5,
    parameter int CH_W      = 12,
    parameter int STRIPE_W  = 16,
    parameter int DRAIN_CYC = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    soft_clr,
    input  logic [LOG2_TOUT:0]      cfg_stripe_len,
    input  logic [CH_W-1:0]         cfg_ch_groups,
    input  logic [STRIPE_W-1:0]     cfg_stripe_num,
    input  logic [2*DW:0]           cfg_recip,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [DW+LOG2_TOUT-1:0] in_dat,
    output logic                    acc_vld,
    output logic [DW+LOG2_TOUT-1:0] acc_dat,
    output logic                    acc_stripe_end,
    output logic                    acc_ch_last,
    output logic                    acc_ch_stripe_end,
    output logic [2*DW:0]           acc_recip,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
);
    localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state;
    logic [LOG2_TOUT:0]    stripe_len_q;
    logic [CH_W-1:0]       ch_groups_q;
    logic [STRIPE_W-1:0]   stripe_num_q;
    logic [LOG2_TOUT:0]    pix_cnt;
    logic [CH_W-1:0]       ch_cnt;
    logic [STRIPE_W-1:0]   str_cnt;
    logic [DCW-1:0]        drain_cnt;

    logic beat, se, cl, cse, last, cfg_ok;

    assign in_rdy = (state == RUN);
    assign busy   = (state != IDLE);
    assign beat   = in_vld & in_rdy;

    assign se   = (pix_cnt == stripe_len_q - {{LOG2_TOUT{1'b0}}, 1'b1});
    assign cl   = (ch_cnt == ch_groups_q - {{(CH_W-1){1'b0}}, 1'b1});
    assign cse  = se & cl;
    assign last = cse & (str_cnt == stripe_num_q - {{(STRIPE_W-1){1'b0}}, 1'b1});

    assign cfg_ok = (cfg_stripe_len != '0) && (cfg_stripe_len <= (LOG2_TOUT+1)'(TOUT)) &&
                    (cfg_ch_groups != '0) && (cfg_stripe_num != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            stripe_len_q      <= '0;
            ch_groups_q       <= '0;
            stripe_num_q      <= '0;
            pix_cnt           <= '0;
            ch_cnt            <= '0;
            str_cnt           <= '0;
            drain_cnt         <= '0;
            acc_vld           <= 1'b0;
            acc_dat           <= '0;
            acc_stripe_end    <= 1'b0;
            acc_ch_last       <= 1'b0;
            acc_ch_stripe_end <= 1'b0;
            acc_recip         <= '0;
            done              <= 1'b0;
            cfg_err           <= 1'b0;
        end else begin
            done              <= 1'b0;
            cfg_err           <= 1'b0;
            acc_vld           <= beat;
            acc_stripe_end    <= beat & se;
            acc_ch_last       <= beat & cl;
            acc_ch_stripe_end <= beat & cse;
            if (beat)
                acc_dat <= in_dat;

            if (soft_clr) begin
                // abort wins over everything, including a same-cycle start; recip is kept
                state             <= IDLE;
                pix_cnt           <= '0;
                ch_cnt            <= '0;
                str_cnt           <= '0;
                drain_cnt         <= '0;
                acc_vld           <= 1'b0;
                acc_stripe_end    <= 1'b0;
                acc_ch_last       <= 1'b0;
                acc_ch_stripe_end <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (cfg_ok) begin
                                stripe_len_q <= cfg_stripe_len;
                                ch_groups_q  <= cfg_ch_groups;
                                stripe_num_q <= cfg_stripe_num;
                                acc_recip    <= cfg_recip;
                                pix_cnt      <= '0;
                                ch_cnt       <= '0;
                                str_cnt      <= '0;
                                state        <= RUN;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (beat) begin
                            if (last) begin
                                pix_cnt   <= '0;
                                ch_cnt    <= '0;
                                str_cnt   <= '0;
                                drain_cnt <= DCW'(DRAIN_CYC - 1);
                                state     <= DRAIN;
                            end else if (se) begin
                                pix_cnt <= '0;
                                if (cl) begin
                                    ch_cnt  <= '0;
                                    str_cnt <= str_cnt + 1'b1;
                                end else begin
                                    ch_cnt <= ch_cnt + 1'b1;
                                end
                            end else begin
                                pix_cnt <= pix_cnt + 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt == '0) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ln_mean_acc_ctrl.sv
// Randomized bench for ln_mean_acc_ctrl against a beat-index flag model.
module tb_ln_mean_acc_ctrl;
    localparam int DW = 16, LOG2_TOUT = 5, DRAIN_CYC = 5;

    logic        clk, rst_n, start, soft_clr, in_vld, in_rdy;
    logic [5:0]  cfg_stripe_len;
    logic [11:0] cfg_ch_groups;
    logic [15:0] cfg_stripe_num;
    logic [32:0] cfg_recip, acc_recip;
    logic [20:0] in_dat, acc_dat;
    logic        acc_vld, acc_stripe_end, acc_ch_last, acc_ch_stripe_end, busy, done, cfg_err;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] cur_recip;

    ln_mean_acc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .soft_clr(soft_clr),
        .cfg_stripe_len(cfg_stripe_len), .cfg_ch_groups(cfg_ch_groups),
        .cfg_stripe_num(cfg_stripe_num), .cfg_recip(cfg_recip),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
        .acc_vld(acc_vld), .acc_dat(acc_dat), .acc_stripe_end(acc_stripe_end),
        .acc_ch_last(acc_ch_last), .acc_ch_stripe_end(acc_ch_stripe_end),
        .acc_recip(acc_recip), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Flags for the k-th beat (1-based) of a job: {stripe_end, ch_last, ch_stripe_end}
    function automatic logic [2:0] exp_flags(input int k, input int L, input int C);
        logic s, c, b;
        s = (k % L) == 0;
        c = (((k - 1) / L) % C) == (C - 1);
        b = (k % (L * C)) == 0;
        return {s, c, b};
    endfunction

    task automatic set_cfg(input int L, input int C, input int S, input logic [32:0] rc);
        cfg_stripe_len = 6'(L);
        cfg_ch_groups  = 12'(C);
        cfg_stripe_num = 16'(S);
        cfg_recip      = rc;
    endtask

    // mode 0: continuous valid, 1: alternating, 2: random. abort_at>0 aborts after that beat.
    task automatic run_job(input int L, input int C, input int S, input logic [32:0] rc,
                           input int mode, input int abort_at);
        int n, k, cyc;
        logic [20:0] d;
        logic take;
        n = L * C * S;
        k = 0;
        cyc = 0;
        set_cfg(L, C, S, rc);
        start = 1'b1;
        step();
        start = 1'b0;
        cur_recip = rc;
        chk("busy_after_start", busy, 1);
        chk("recip_after_start", acc_recip, rc);
        while (k < n && cyc < 4000) begin
            case (mode)
                0:       in_vld = 1'b1;
                1:       in_vld = (cyc % 2) == 0;
                default: in_vld = ($urandom % 3) != 0;
            endcase
            d = 21'($urandom);
            in_dat = d;
            start = ($urandom % 8) == 0;
            chk("in_rdy_run", in_rdy, 1);
            take = in_vld;
            step();
            cyc++;
            if (take) begin
                k++;
                chk("beat", {acc_vld, acc_dat, acc_stripe_end, acc_ch_last, acc_ch_stripe_end},
                    {1'b1, d, exp_flags(k, L, C)});
            end else begin
                chk("bubble", {acc_vld, acc_stripe_end, acc_ch_last, acc_ch_stripe_end}, 0);
            end
            chk("cfg_err_run", cfg_err, 0);
            if (abort_at != 0 && k == abort_at) begin
                in_vld = 1'b0;
                soft_clr = 1'b1;
                start = 1'b1;
                step();
                soft_clr = 1'b0;
                start = 1'b0;
                chk("abort_vld", acc_vld, 0);
                chk("abort_busy", busy, 0);
                chk("abort_rdy", in_rdy, 0);
                for (int i = 0; i < 8; i++) begin
                    step();
                    chk("abort_no_done", {done, busy}, 0);
                end
                chk("abort_recip", acc_recip, rc);
                return;
            end
        end
        start = 1'b0;
        if (k < n) chk("job_timeout", k, n);
        for (int dcy = 1; dcy <= DRAIN_CYC + 2; dcy++) begin
            in_vld = $urandom % 2;
            step();
            chk("drain_done", done, (dcy == DRAIN_CYC));
            chk("drain_busy", busy, (dcy < DRAIN_CYC));
            chk("drain_vld", acc_vld, 0);
            chk("drain_rdy", in_rdy, 0);
        end
        in_vld = 1'b0;
        chk("recip_hold", acc_recip, rc);
    endtask

    task automatic bad_start(input int L, input int C, input int S);
        set_cfg(L, C, S, {1'b1, $urandom});
        start = 1'b1;
        step();
        start = 1'b0;
        chk("cfg_err_pulse", cfg_err, 1);
        chk("cfg_err_busy", busy, 0);
        chk("cfg_err_rdy", in_rdy, 0);
        chk("cfg_err_recip", acc_recip, cur_recip);
        step();
        chk("cfg_err_single", cfg_err, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        soft_clr = 1'b0;
        in_vld = 1'b0;
        in_dat = '0;
        cur_recip = '0;
        set_cfg(4, 3, 2, 33'h0);
        #12;
        chk("reset_ctrl", {in_rdy, acc_vld, acc_stripe_end, acc_ch_last, acc_ch_stripe_end,
                           busy, done, cfg_err}, 0);
        chk("reset_dat", acc_dat, 0);
        chk("reset_recip", acc_recip, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        run_job(4, 3, 2, 33'h1_2345_6789, 0, 0);
        run_job(4, 3, 2, 33'h0_0F0F_0F0F, 1, 0);
        run_job(1, 1, 3, 33'h1_5555_AAAA, 0, 0);
        run_job(32, 2, 1, 33'h0_0000_0400, 0, 0);

        bad_start(0, 3, 2);
        bad_start(33, 3, 2);
        bad_start(4, 0, 2);
        bad_start(4, 3, 0);

        run_job(4, 3, 2, 33'h1_0000_0001, 0, 7);
        run_job(4, 3, 2, 33'h0_ABCD_EF01, 0, 0);

        // soft_clr with start in IDLE: start is dropped
        set_cfg(2, 2, 1, 33'h1_FFFF_0000);
        start = 1'b1;
        soft_clr = 1'b1;
        step();
        start = 1'b0;
        soft_clr = 1'b0;
        chk("clr_start_busy", busy, 0);
        chk("clr_start_recip", acc_recip, cur_recip);

        for (int j = 0; j < 6; j++)
            run_job(int'($urandom_range(1, 32)), int'($urandom_range(1, 4)),
                    int'($urandom_range(1, 3)), {1'($urandom), $urandom}, 2, 0);

        // asynchronous reset in the middle of a job
        set_cfg(4, 3, 2, 33'h1_1111_2222);
        start = 1'b1;
        step();
        start = 1'b0;
        in_vld = 1'b1;
        for (int i = 0; i < 5; i++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctrl", {in_rdy, acc_vld, acc_stripe_end, acc_ch_last, acc_ch_stripe_end,
                          busy, done, cfg_err}, 0);
        chk("arst_recip", acc_recip, 0);
        in_vld = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        cur_recip = '0;
        run_job(3, 2, 2, 33'h0_7777_8888, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ln_mean_acc_ctrl.md
Name: ln_mean_acc_ctrl

Overview:
Sequencer for the LayerNorm stage-1 mean/square accumulator.
- Accepts a per-layer job configuration with a start/done handshake.
- Gates the incoming channel-group data stream with a valid/ready handshake.
- Generates the accumulator's loop flags (stripe end, last channel group, combined end) and holds the reciprocal-of-channel-count operand.
- Sits between the CMAC-side LN data source and the mean accumulator, one instance per LN lane.

Parameters:
- DW, 16, base data width (matches MAX_DAT_DW).
- TOUT, 32, accumulator buffer depth; upper bound on stripe length.
- LOG2_TOUT, 5, log2(TOUT).
- CH_W, 12, width of the channel-group count.
- STRIPE_W, 16, width of the stripe count.
- DRAIN_CYC, 5, cycles from the last accepted beat to the accumulator's last output valid.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle job start; sampled only in IDLE
- soft_clr  in  1  synchronous abort to IDLE
- cfg_stripe_len  in  LOG2_TOUT+1  pixels per stripe, 1..TOUT
- cfg_ch_groups  in  CH_W  channel groups per stripe, >=1
- cfg_stripe_num  in  STRIPE_W  stripes per job, >=1
- cfg_recip  in  2*DW+1  reciprocal of the channel count, unsigned
- in_vld  in  1  source data valid
- in_rdy  out  1  controller ready
- in_dat  in  DW+LOG2_TOUT  source data
- acc_vld  out  1  to accumulator dat_vld_i
- acc_dat  out  DW+LOG2_TOUT  to accumulator dat_i
- acc_stripe_end  out  1  to Stripe_loop_end
- acc_ch_last  out  1  to CH_acc_max_now
- acc_ch_stripe_end  out  1  to CH_and_Stripe_loop_end
- acc_recip  out  2*DW+1  to recip_CH_int16
- busy  out  1  state != IDLE
- done  out  1  single-cycle job-complete pulse
- cfg_err  out  1  single-cycle pulse on a rejected start

Behaviour:
- Reset:
  - State IDLE; all counters 0.
  - in_rdy, acc_vld, acc_* flags, busy, done, cfg_err are 0; acc_dat and acc_recip are 0.
- States:
  - IDLE -> RUN on a valid start.
  - RUN -> DRAIN on acceptance of the last beat.
  - DRAIN -> IDLE after DRAIN_CYC cycles, with done pulsed on the exiting cycle.
- Start:
  - In IDLE, latch all cfg_* fields and drive acc_recip from the latched cfg_recip.
  - A start is invalid if stripe_len==0, stripe_len>TOUT, ch_groups==0 or stripe_num==0. An invalid start pulses cfg_err on the next cycle and stays in IDLE.
  - start outside IDLE is ignored and cfg_err is not asserted.
- Handshake:
  - in_rdy = (state==RUN), combinational from state.
  - A beat is accepted when in_vld & in_rdy.
- Counters, all advancing only on accepted beats:
  - pix_cnt (0..stripe_len-1).
  - ch_cnt (0..ch_groups-1).
  - str_cnt (0..stripe_num-1).
  - se = (pix_cnt==stripe_len-1).
  - cl = (ch_cnt==ch_groups-1).
  - cse = se & cl.
  - last = cse & (str_cnt==stripe_num-1).
  - pix_cnt wraps to 0 on se.
  - ch_cnt increments on se and wraps to 0 on cse.
  - str_cnt increments on cse.
- Output register (latency 1):
  - On an accepted beat, the next cycle has acc_vld=1, acc_dat=in_dat, acc_stripe_end=se, acc_ch_last=cl, acc_ch_stripe_end=cse.
  - Otherwise acc_vld=0 and all three flags=0; acc_dat holds its previous value.
  - Flags are never asserted without acc_vld.
- Degenerate cases:
  - stripe_len==1: se on every beat.
  - ch_groups==1: cl on every beat, so each beat set is both first and last group.
- Drain:
  - The drain counter loads DRAIN_CYC-1 on the last beat and counts down in DRAIN.
  - done is asserted when the counter reaches 0 in DRAIN, then the state returns to IDLE.
  - busy stays 1 through DRAIN.
- acc_recip holds its value between jobs and changes only on a valid start.
- soft_clr:
  - Highest priority in any state: next cycle IDLE, counters 0, acc_vld and flags 0, no done.
  - acc_recip is retained.
  - soft_clr together with start: soft_clr wins and the start is dropped.
- in_vld while not RUN is not accepted; the source must hold its data.
- Asynchronous reset mid-job returns everything immediately to reset values.

Test Plan:
- Basic job: stripe_len=4, ch_groups=3, stripe_num=2, continuous in_vld. Expect:
  - 24 acc_vld beats.
  - acc_stripe_end on beats 4,8,12,16,20,24.
  - acc_ch_last on beats 9-12 and 21-24.
  - acc_ch_stripe_end on beats 12 and 24.
  - done exactly DRAIN_CYC cycles after beat 24 is accepted.
- Bubbles: same config with in_vld toggling 1,0,1,0. Expect the flag positions by beat index identical to the basic job, and no flag on any acc_vld=0 cycle.
- Degenerate: stripe_len=1, ch_groups=1, stripe_num=3. Expect every acc_vld beat to carry all three flags, then done after 3 beats plus the drain.
- Full depth: stripe_len=32, ch_groups=2, stripe_num=1. Expect:
  - pix_cnt wraps at 31.
  - acc_stripe_end on beats 32 and 64.
  - acc_ch_stripe_end only on beat 64.
- Config errors: start with stripe_len=0, then 33, then ch_groups=0. Expect a cfg_err pulse each time, busy=0, and in_rdy=0.
- Abort: soft_clr after beat 7 of the basic job, then a restart. Expect:
  - acc_vld=0 on the next cycle and no done for the aborted job.
  - The restarted job reproduces the basic-job flag positions from beat 1.
  - acc_recip keeps its value after soft_clr.
